regfile_mp: RTL and testbench

- Parametrised multi-read-port register file for the MIPS core; next generation of the single-file 2R/1W register bank.
- Adds N registered read ports, write-to-read bypass, a per-register pending-write scoreboard, a hardwired zero register and asynchronous clear.
- Sits between decode (reads, reservations) and writeback (writes).
- Keeps the syscall ($v0) and stdout-address ($a0) taps used by the syscall unit.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_mp_if.sv | 37 +++
 rtl/regfile_read_port.sv | 68 ++++++
 rtl/regfile_mp.sv | 82 ++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_pkg : shared constants and types for the MIPS register file |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
package regfile_pkg;

    localparam int REGFILE_DATA_W = 32;
    localparam int REGFILE_ADDR_W = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_V0   = 2;
    localparam int REG_A0   = 4;
    localparam int REG_RA   = 31;

    typedef logic [REGFILE_ADDR_W-1:0] reg_addr_t;
    typedef logic [REGFILE_DATA_W-1:0] reg_data_t;

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_mp_if : decode/writeback bus of the multi-port register file |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic [DATA_W-1:0]        wr_data;
    logic                     rsv_en;
    logic [ADDR_W-1:0]        rsv_addr;
    logic [DEPTH-1:0]         busy_vec;
    logic [DATA_W-1:0]        sys_call_reg;
    logic [DATA_W-1:0]        std_out_address;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_vec, sys_call_reg, std_out_address
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_vec, sys_call_reg, std_out_address
    );
endinterface
`default_nettype wire

// File: rtl/regfile_read_port.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_read_port : one registered read port with bypass and busy    |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = REGFILE_DATA_W,
    parameter int ADDR_W = REGFILE_ADDR_W,
    parameter int DEPTH  = 32,
    parameter int BYPASS = 1
) (
    input  wire logic                         clk,
    input  wire logic                         rst_n,
    input  wire logic                         rd_en_i,
    input  wire logic [ADDR_W-1:0]            rd_addr_i,
    input  wire logic [DEPTH-1:0][DATA_W-1:0] regs_i,
    input  wire logic [DEPTH-1:0]             busy_i,
    input  wire logic                         wr_en_i,
    input  wire logic [ADDR_W-1:0]            wr_addr_i,
    input  wire logic [DATA_W-1:0]            wr_data_i,
    output logic      [DATA_W-1:0]            rd_data_o,
    output logic                              rd_busy_o
);
    logic              w_hit;
    logic [DATA_W-1:0] w_reg_data;
    logic              w_reg_busy;
    logic              w_wr_match;
    logic [DATA_W-1:0] rd_data_d, rd_data_q;
    logic              rd_busy_d, rd_busy_q;

    always_comb begin
        w_hit      = 1'b0;
        w_reg_data = '0;
        w_reg_busy = 1'b0;
        for (int r = 0; r < DEPTH; r++) begin
            if (rd_addr_i == ADDR_W'(r)) begin
                w_hit      = 1'b1;
                w_reg_data = regs_i[r];
                w_reg_busy = busy_i[r];
            end
        end
        // Register zero reads as zero regardless of what storage holds
        if (rd_addr_i == ADDR_W'(REG_ZERO)) begin
            w_hit      = 1'b0;
            w_reg_data = '0;
            w_reg_busy = 1'b0;
        end
        w_wr_match = w_hit && wr_en_i && (wr_addr_i == rd_addr_i);
        rd_data_d  = ((BYPASS != 0) && w_wr_match) ? wr_data_i : w_reg_data;
        rd_busy_d  = w_reg_busy && !w_wr_match;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
            rd_busy_q <= 1'b0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign rd_data_o = rd_data_q;
    assign rd_busy_o = rd_busy_q;
endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | regfile_mp : N-read-port register file with scoreboard and taps      |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W      = REGFILE_DATA_W,
    parameter int ADDR_W      = REGFILE_ADDR_W,
    parameter int DEPTH       = 32,
    parameter int NUM_RD      = 2,
    parameter int BYPASS      = 1,
    parameter int SYSCALL_IDX = REG_V0,
    parameter int STDOUT_IDX  = REG_A0
) (
    input wire logic    clk,
    input wire logic    rst_n,
    regfile_mp_if.slave bus
);
    if (DEPTH > (1 << ADDR_W)) begin : g_chk_depth
        $fatal(1, "regfile_mp: DEPTH exceeds 2**ADDR_W");
    end
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_chk_num_rd
        $fatal(1, "regfile_mp: NUM_RD must be within 1..4");
    end
    if (SYSCALL_IDX >= DEPTH || STDOUT_IDX >= DEPTH) begin : g_chk_taps
        $fatal(1, "regfile_mp: tap index outside implemented registers");
    end

    logic [DEPTH-1:0][DATA_W-1:0] regs_q;
    logic [DEPTH-1:0]             busy_q;
    logic [NUM_RD*DATA_W-1:0]     w_rd_data;
    logic [NUM_RD-1:0]            w_rd_busy;

    // Entry 0 and addresses >= DEPTH never match the loop, so they are ignored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
            busy_q <= '0;
        end else begin
            for (int r = REG_ZERO + 1; r < DEPTH; r++) begin
                if (bus.wr_en && bus.wr_addr == ADDR_W'(r)) begin
                    regs_q[r] <= bus.wr_data;
                end
                if (bus.rsv_en && bus.rsv_addr == ADDR_W'(r)) begin
                    busy_q[r] <= 1'b1;
                end else if (bus.wr_en && bus.wr_addr == ADDR_W'(r)) begin
                    busy_q[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .DEPTH  (DEPTH),
            .BYPASS (BYPASS)
        ) u_port (
            .clk       (clk),
            .rst_n     (rst_n),
            .rd_en_i   (bus.rd_en[i]),
            .rd_addr_i (bus.rd_addr[i*ADDR_W +: ADDR_W]),
            .regs_i    (regs_q),
            .busy_i    (busy_q),
            .wr_en_i   (bus.wr_en),
            .wr_addr_i (bus.wr_addr),
            .wr_data_i (bus.wr_data),
            .rd_data_o (w_rd_data[i*DATA_W +: DATA_W]),
            .rd_busy_o (w_rd_busy[i])
        );
    end

    assign bus.rd_data         = w_rd_data;
    assign bus.rd_busy         = w_rd_busy;
    assign bus.busy_vec        = busy_q;
    assign bus.sys_call_reg    = regs_q[SYSCALL_IDX];
    assign bus.std_out_address = regs_q[STDOUT_IDX];
endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_regfile_mp : two register-file configurations against one model   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
module tb_regfile_mp;
    import regfile_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  s_rd_en;
    logic [9:0]  s_rd_addr;
    logic        s_wr_en;
    logic [4:0]  s_wr_addr;
    logic [31:0] s_wr_data;
    logic        s_rsv_en;
    logic [4:0]  s_rsv_addr;
    int          n_cmp = 0;
    int          n_bad = 0;

    // Instance a: 32 regs, bypass on. Instance b: 16 regs, bypass off.
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2)) bus_a ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_RD(2)) bus_b ();

    assign bus_a.rd_en = s_rd_en;     assign bus_b.rd_en = s_rd_en;
    assign bus_a.rd_addr = s_rd_addr; assign bus_b.rd_addr = s_rd_addr;
    assign bus_a.wr_en = s_wr_en;     assign bus_b.wr_en = s_wr_en;
    assign bus_a.wr_addr = s_wr_addr; assign bus_b.wr_addr = s_wr_addr;
    assign bus_a.wr_data = s_wr_data; assign bus_b.wr_data = s_wr_data;
    assign bus_a.rsv_en = s_rsv_en;   assign bus_b.rsv_en = s_rsv_en;
    assign bus_a.rsv_addr = s_rsv_addr; assign bus_b.rsv_addr = s_rsv_addr;

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(32), .NUM_RD(2), .BYPASS(1),
                 .SYSCALL_IDX(2), .STDOUT_IDX(4))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .DEPTH(16), .NUM_RD(2), .BYPASS(0),
                 .SYSCALL_IDX(2), .STDOUT_IDX(4))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

    always #5 clk = ~clk;

    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    logic [31:0] m_rdd  [2][2];
    logic        m_rdb  [2][2];

    function automatic int depth_of(int d);
        return (d == 0) ? 32 : 16;
    endfunction

    function automatic bit valid(int d, int a);
        return (a != 0) && (a < depth_of(d));
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) begin
                m_mem[d][r]  = '0;
                m_busy[d][r] = 1'b0;
            end
            for (int p = 0; p < 2; p++) begin
                m_rdd[d][p] = '0;
                m_rdb[d][p] = 1'b0;
            end
        end
    endtask

    // Reads see the state before this edge; the write and reservation land after.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                int a;
                bit hit;
                a   = int'(s_rd_addr[p*5 +: 5]);
                hit = s_wr_en && (int'(s_wr_addr) == a) && valid(d, a);
                if (s_rd_en[p]) begin
                    if (!valid(d, a)) begin
                        m_rdd[d][p] = '0;
                        m_rdb[d][p] = 1'b0;
                    end else begin
                        m_rdd[d][p] = (hit && d == 0) ? s_wr_data : m_mem[d][a];
                        m_rdb[d][p] = m_busy[d][a] && !hit;
                    end
                end
            end
            if (s_wr_en && valid(d, int'(s_wr_addr))) begin
                m_mem[d][s_wr_addr]  = s_wr_data;
                m_busy[d][s_wr_addr] = 1'b0;
            end
            if (s_rsv_en && valid(d, int'(s_rsv_addr)))
                m_busy[d][s_rsv_addr] = 1'b1;
        end
    endtask

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(string tag, int d, logic [63:0] rdd, logic [1:0] rdb,
                           logic [31:0] bv, logic [31:0] sys, logic [31:0] so);
        logic [31:0] ebv;
        ebv = '0;
        for (int r = 0; r < 32; r++) ebv[r] = m_busy[d][r];
        for (int p = 0; p < 2; p++) begin
            chk($sformatf("%s_d%0d_rd_data%0d", tag, d, p), 64'(rdd[p*32 +: 32]), 64'(m_rdd[d][p]));
            chk($sformatf("%s_d%0d_rd_busy%0d", tag, d, p), 64'(rdb[p]), 64'(m_rdb[d][p]));
        end
        chk($sformatf("%s_d%0d_busy_vec", tag, d), 64'(bv), 64'(ebv));
        chk($sformatf("%s_d%0d_sys_call", tag, d), 64'(sys), 64'(m_mem[d][2]));
        chk($sformatf("%s_d%0d_std_out", tag, d), 64'(so), 64'(m_mem[d][4]));
    endtask

    task automatic check_all(string tag);
        chk_dut(tag, 0, bus_a.rd_data, bus_a.rd_busy, bus_a.busy_vec,
                bus_a.sys_call_reg, bus_a.std_out_address);
        chk_dut(tag, 1, bus_b.rd_data, bus_b.rd_busy, 32'(bus_b.busy_vec),
                bus_b.sys_call_reg, bus_b.std_out_address);
    endtask

    task automatic step(string tag);
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        check_all(tag);
        s_rd_en  = '0;
        s_wr_en  = 1'b0;
        s_rsv_en = 1'b0;
    endtask

    task automatic wr(int a, logic [31:0] v);
        s_wr_en = 1'b1; s_wr_addr = 5'(a); s_wr_data = v;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        s_rd_en = '0; s_rd_addr = '0; s_wr_en = 1'b0; s_wr_addr = '0;
        s_wr_data = '0; s_rsv_en = 1'b0; s_rsv_addr = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Asynchronous reset between edges clears storage and outputs at once
        wr(5, 32'hDEADBEEF); step("wr5");
        s_rd_en = 2'b01; s_rd_addr = 10'd5; step("rd5");
        chk("rd5_a", 64'(bus_a.rd_data[31:0]), 64'hDEADBEEF);
        chk("rd5_b", 64'(bus_b.rd_data[31:0]), 64'hDEADBEEF);
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst_rd_a", 64'(bus_a.rd_data[31:0]), 64'h0);
        #1 rst_n = 1'b1;
        s_rd_en = 2'b01; s_rd_addr = 10'd5; step("rd5_post_rst");
        chk("rd5_post_rst_a", 64'(bus_a.rd_data[31:0]), 64'h0);

        // Zero register
        wr(0, 32'h12345678); s_rsv_en = 1'b1; s_rsv_addr = 5'd0; step("wr0");
        s_rd_en = 2'b11; s_rd_addr = {5'd0, 5'd0}; step("rd0");
        chk("rd0_data_a", 64'(bus_a.rd_data), 64'h0);
        chk("rd0_busy_a", 64'(bus_a.rd_busy), 64'h0);
        chk("rd0_bv0_a", 64'(bus_a.busy_vec[0]), 64'h0);

        // Latency and hold
        wr(7, 32'hA5A5A5A5); step("wr7");
        s_rd_en = 2'b10; s_rd_addr = {5'd7, 5'd0}; step("rd7");
        chk("rd7_a", 64'(bus_a.rd_data[63:32]), 64'hA5A5A5A5);
        wr(7, 32'h1); step("hold7");
        chk("hold7_a", 64'(bus_a.rd_data[63:32]), 64'hA5A5A5A5);
        chk("hold7_b", 64'(bus_b.rd_data[63:32]), 64'hA5A5A5A5);

        // Bypass versus pre-write value
        wr(9, 32'h11); step("wr9");
        wr(9, 32'h22); s_rd_en = 2'b11; s_rd_addr = {5'd9, 5'd9}; step("byp9");
        chk("byp9_a", 64'(bus_a.rd_data), {32'h22, 32'h22});
        chk("byp9_b", 64'(bus_b.rd_data), {32'h11, 32'h11});
        s_rd_en = 2'b11; s_rd_addr = {5'd9, 5'd9}; step("rd9");
        chk("rd9_b", 64'(bus_b.rd_data), {32'h22, 32'h22});

        // Scoreboard
        s_rsv_en = 1'b1; s_rsv_addr = 5'd3; step("rsv3");
        chk("rsv3_a", 64'(bus_a.busy_vec[3]), 64'h1);
        s_rsv_en = 1'b1; s_rsv_addr = 5'd3; wr(3, 32'h33); step("rsv_wr3");
        chk("rsv_wr3_a", 64'(bus_a.busy_vec[3]), 64'h1);
        s_rd_en = 2'b01; s_rd_addr = 10'd3; step("rd3_busy");
        chk("rd3_busy_a", 64'(bus_a.rd_busy[0]), 64'h1);
        wr(3, 32'h34); s_rd_en = 2'b01; s_rd_addr = 10'd3; step("wr3");
        chk("wr3_bv_b", 64'(bus_b.busy_vec[3]), 64'h0);
        chk("wr3_rdb_b", 64'(bus_b.rd_busy[0]), 64'h0);

        // Taps and range
        wr(2, 32'd10); step("wr2");
        chk("tap_sys_a", 64'(bus_a.sys_call_reg), 64'd10);
        wr(4, 32'h1000); step("wr4");
        chk("tap_so_b", 64'(bus_b.std_out_address), 64'h1000);
        wr(20, 32'hABCD); step("wr20");
        s_rd_en = 2'b01; s_rd_addr = 10'd20; step("rd20");
        chk("rd20_a", 64'(bus_a.rd_data[31:0]), 64'hABCD);
        chk("rd20_b", 64'(bus_b.rd_data[31:0]), 64'h0);

        // Random traffic with frequent address collisions
        for (int n = 0; n < 400; n++) begin
            s_rd_en    = 2'($urandom_range(0, 3));
            s_rd_addr  = 10'($urandom);
            s_wr_en    = 1'($urandom_range(0, 1));
            s_wr_addr  = 5'($urandom_range(0, 31));
            s_wr_data  = $urandom;
            s_rsv_en   = 1'($urandom_range(0, 1));
            s_rsv_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) == 0) s_wr_addr  = s_rd_addr[4:0];
            if ($urandom_range(0, 3) == 0) s_rsv_addr = s_wr_addr;
            if ($urandom_range(0, 4) == 0) s_rd_addr[9:5] = s_rd_addr[4:0];
            if (n == 200) rst_n = 1'b0;
            step("rnd");
            rst_n = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
